// File: rtl/debug_latch_reader.sv
// Snapshots the pipeline latch words on a start request and streams them out byte by byte
// over a valid/ready handshake. Define DEBUG_READER_CKSUM_EN to append an XOR checksum byte.
module debug_latch_reader #(
    parameter int LATCH_W     = 64,
    parameter int NUM_LATCHES = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [NUM_LATCHES*LATCH_W-1:0] latch_bus,
    input  logic                           tx_ready,
    output logic                           tx_valid,
    output logic [7:0]                     tx_data,
    output logic                           busy,
    output logic                           done
);

    localparam int BUS_W = NUM_LATCHES * LATCH_W;
    localparam int BYTES = BUS_W / 8;
    localparam int IDX_W = $clog2(BYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

`ifdef DEBUG_READER_CKSUM_EN
    typedef enum logic [1:0] {IDLE, SEND, CKSUM, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
`endif

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [BUS_W-1:0]   snapshot;
    logic [7:0]         cur_byte;
    logic               accept;
    logic               send_xfer;
`ifdef DEBUG_READER_CKSUM_EN
    logic [7:0]         cksum;
`endif

    // Byte k of the snapshot lives at bits [8k+7:8k]; latch 0 goes out first.
    assign cur_byte  = 8'(snapshot >> {idx, 3'b000});
    assign accept    = (state == IDLE) && start;
    assign send_xfer = (state == SEND) && tx_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = SEND;
            end
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = cur_byte;
                if (tx_ready && (idx == LAST_IDX)) begin
`ifdef DEBUG_READER_CKSUM_EN
                    state_nxt = CKSUM;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef DEBUG_READER_CKSUM_EN
            CKSUM: begin
                tx_valid = 1'b1;
                tx_data  = cksum;
                if (tx_ready) state_nxt = DONE;
            end
`endif
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The snapshot is frozen for the whole dump; the index ends at BYTES and never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snapshot <= '0;
            idx      <= '0;
        end else if (accept) begin
            snapshot <= latch_bus;
            idx      <= '0;
        end else if (send_xfer) begin
            idx      <= idx + 1'b1;
        end
    end

`ifdef DEBUG_READER_CKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cksum <= 8'h00;
        end else if (accept) begin
            cksum <= 8'h00;
        end else if (send_xfer) begin
            cksum <= cksum ^ cur_byte;
        end
    end
`endif

endmodule

// File: tb/tb_debug_latch_reader.sv
// Randomized self-checking bench for debug_latch_reader; expected byte streams come from
// a queue-based model of the dump format (payload bytes, optional XOR checksum byte).
module tb_debug_latch_reader;

    localparam int LATCH_W     = 64;
    localparam int NUM_LATCHES = 4;
    localparam int BUS_W       = NUM_LATCHES * LATCH_W;
    localparam int BYTES       = BUS_W / 8;
`ifdef DEBUG_READER_CKSUM_EN
    localparam int DUMP_N      = BYTES + 1;
`else
    localparam int DUMP_N      = BYTES;
`endif
    localparam int LIMIT       = 400;

    logic             clk;
    logic             reset;
    logic             start;
    logic [BUS_W-1:0] latch_bus;
    logic             tx_ready;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    int         done_cnt;
    int         holds_bad;
    logic       first_v;
    int         first_x;
    int         last_x;
    int         done_cyc;
    logic       busy_after;
    logic       timed_out;

    debug_latch_reader #(.LATCH_W(LATCH_W), .NUM_LATCHES(NUM_LATCHES)) dut (
        .clk(clk), .reset(reset), .start(start), .latch_bus(latch_bus),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void build_exp(input logic [BUS_W-1:0] snap);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        exp_q.delete();
        for (int k = 0; k < BYTES; k++) begin
            b = snap[8*k +: 8];
            exp_q.push_back(b);
            x = x ^ b;
        end
`ifdef DEBUG_READER_CKSUM_EN
        exp_q.push_back(x);
`endif
    endfunction

    function automatic logic [BUS_W-1:0] rand_snap();
        logic [BUS_W-1:0] s;
        for (int w = 0; w < BUS_W / 32; w++) s[32*w +: 32] = $urandom();
        return s;
    endfunction

    // mode 0: ready always high, 1: ready pattern 1,0,0,1 repeating, 2: random ready.
    task automatic collect(input logic [BUS_W-1:0] snap, input int mode, input int restart_at,
                           input logic zero_after, input int stop_after);
        logic       r;
        logic       prev_hold;
        logic [7:0] prev_d;
        logic       finished;
        got_q.delete();
        done_cnt = 0; holds_bad = 0; first_x = -1; last_x = -1; done_cyc = -1;
        busy_after = 1'bx; prev_hold = 1'b0; prev_d = 8'h00; finished = 1'b0;
        @(negedge clk);
        latch_bus = snap; start = 1'b1; tx_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        first_v = tx_valid;
        if (zero_after) latch_bus = '0;
        for (int cyc = 0; cyc < LIMIT; cyc++) begin
            if (cyc > 0) @(negedge clk);
            start = 1'b0;
            if (prev_hold && (tx_valid !== 1'b1 || tx_data !== prev_d)) holds_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                busy_after = busy;
                finished = 1'b1;
                break;
            end
            if (mode == 0)      r = 1'b1;
            else if (mode == 1) r = (cyc % 4 == 0) || (cyc % 4 == 3);
            else                r = ($urandom_range(2) != 0);
            tx_ready = r;
            prev_hold = tx_valid && !r;
            prev_d = tx_data;
            if (tx_valid === 1'b1 && r) begin
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
                got_q.push_back(tx_data);
                if (got_q.size() == restart_at) start = 1'b1;
                if (got_q.size() == stop_after) begin
                    finished = 1'b1;
                    break;
                end
            end
        end
        timed_out = !finished;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; tx_ready = 1'b0; latch_bus = '0;
        @(negedge clk);
        total++;
        if ({tx_valid, busy, done, tx_data} !== 11'h0) begin
            bad++;
            $display("FAIL reset_state: got v=%b busy=%b done=%b data=%h expected all zero",
                     tx_valid, busy, done, tx_data);
        end
        @(negedge clk);
        reset = 1'b0;
        latch_bus = rand_snap();
        latch_bus[7:0] = 8'hA5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            bad++;
            $display("FAIL reset_pre_first_byte: got v=%b data=%h expected v=1 data=a5", tx_valid, tx_data);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({tx_valid, busy, done, tx_data} !== 11'h0) begin
            bad++;
            $display("FAIL reset_async: got v=%b busy=%b done=%b data=%h expected all zero",
                     tx_valid, busy, done, tx_data);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_full_speed();
        logic [BUS_W-1:0] snap;
        int nbad;
        snap = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
        build_exp(snap);
        collect(snap, 0, -1, 1'b0, -1);
        total++;
        if (timed_out) begin bad++; $display("FAIL full_timeout: got no completion expected done within %0d cycles", LIMIT); end
        total++;
        if (first_v !== 1'b1 || first_x != 0) begin
            bad++;
            $display("FAIL full_latency: got valid=%b first_xfer=%0d expected 1 and 0", first_v, first_x);
        end
        nbad = 0;
        for (int i = 0; i < BYTES; i++) begin
            if (i >= got_q.size() || got_q[i] !== 8'(8'h11 * (i / 8 + 1))) nbad++;
        end
        total++;
        if (got_q.size() != DUMP_N || nbad != 0) begin
            bad++;
            $display("FAIL full_bytes: got %0d bytes with %0d wrong expected %0d bytes", got_q.size(), nbad, DUMP_N);
        end
        total++;
        if (last_x - first_x != DUMP_N - 1) begin
            bad++;
            $display("FAIL full_no_bubbles: got span %0d expected %0d", last_x - first_x, DUMP_N - 1);
        end
        total++;
        if (done_cnt != 1 || done_cyc != last_x + 1 || busy_after !== 1'b0) begin
            bad++;
            $display("FAIL full_done: got count=%0d cyc=%0d busy_after=%b expected 1 %0d 0",
                     done_cnt, done_cyc, busy_after, last_x + 1);
        end
`ifdef DEBUG_READER_CKSUM_EN
        total++;
        if (got_q.size() != DUMP_N || got_q[BYTES] !== 8'h00) begin
            bad++;
            $display("FAIL full_cksum: got %h expected 00", got_q.size() == DUMP_N ? got_q[BYTES] : 8'hxx);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [BUS_W-1:0] snap;
        int nbad;
        snap = rand_snap();
        snap[63:0] = 64'h0807060504030201;
        build_exp(snap);
        collect(snap, 1, -1, 1'b0, -1);
        total++;
        if (timed_out) begin bad++; $display("FAIL bp_timeout: got no completion expected done within %0d cycles", LIMIT); end
        nbad = 0;
        for (int i = 0; i < 8; i++) if (i >= got_q.size() || got_q[i] !== 8'(i + 1)) nbad++;
        total++;
        if (nbad != 0) begin bad++; $display("FAIL bp_first8: got %0d wrong bytes expected 0", nbad); end
        nbad = 0;
        foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) nbad++;
        total++;
        if (got_q.size() != exp_q.size() || nbad != 0) begin
            bad++;
            $display("FAIL bp_bytes: got %0d bytes with %0d wrong expected %0d", got_q.size(), nbad, exp_q.size());
        end
        total++;
        if (holds_bad != 0) begin bad++; $display("FAIL bp_hold: got %0d unstable stalls expected 0", holds_bad); end
    endtask

    task automatic test_start_while_busy();
        logic [BUS_W-1:0] snap;
        int nbad;
        snap = rand_snap();
        build_exp(snap);
        collect(snap, 0, 5, 1'b1, -1);
        total++;
        if (timed_out) begin bad++; $display("FAIL busy_timeout: got no completion expected done within %0d cycles", LIMIT); end
        nbad = 0;
        foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) nbad++;
        total++;
        if (got_q.size() != exp_q.size() || nbad != 0) begin
            bad++;
            $display("FAIL busy_bytes: got %0d bytes with %0d wrong expected %0d", got_q.size(), nbad, exp_q.size());
        end
        total++;
        if (done_cnt != 1 || busy_after !== 1'b0) begin
            bad++;
            $display("FAIL busy_done: got count=%0d busy_after=%b expected 1 and 0", done_cnt, busy_after);
        end
    endtask

    task automatic test_reset_mid_dump();
        logic [BUS_W-1:0] snap;
        int stray_done;
        int nbad;
        snap = rand_snap();
        collect(snap, 0, -1, 1'b0, 10);
        total++;
        if (timed_out || got_q.size() != 10) begin
            bad++;
            $display("FAIL abort_reach: got %0d bytes expected 10", got_q.size());
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_async: got v=%b busy=%b expected 0 0", tx_valid, busy);
        end
        stray_done = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) stray_done++;
        end
        total++;
        if (stray_done != 0) begin bad++; $display("FAIL abort_no_done: got %0d active cycles expected 0", stray_done); end
        snap = rand_snap();
        build_exp(snap);
        collect(snap, 2, -1, 1'b0, -1);
        total++;
        if (got_q.size() == 0 || got_q[0] !== snap[7:0]) begin
            bad++;
            $display("FAIL abort_restart_b0: got %h expected %h", got_q.size() ? got_q[0] : 8'hxx, snap[7:0]);
        end
        nbad = 0;
        foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) nbad++;
        total++;
        if (timed_out || got_q.size() != exp_q.size() || nbad != 0 || done_cnt != 1) begin
            bad++;
            $display("FAIL abort_restart: got %0d bytes with %0d wrong done=%0d expected %0d bytes done=1",
                     got_q.size(), nbad, done_cnt, exp_q.size());
        end
    endtask

    task automatic test_random();
        logic [BUS_W-1:0] snap;
        int nbad;
        for (int it = 0; it < 4; it++) begin
            snap = rand_snap();
            build_exp(snap);
            collect(snap, 2, -1, 1'b0, -1);
            nbad = 0;
            foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) nbad++;
            total++;
            if (timed_out || got_q.size() != exp_q.size() || nbad != 0) begin
                bad++;
                $display("FAIL rand_bytes[%0d]: got %0d bytes with %0d wrong expected %0d", it, got_q.size(), nbad, exp_q.size());
            end
            total++;
            if (holds_bad != 0) begin bad++; $display("FAIL rand_hold[%0d]: got %0d unstable stalls expected 0", it, holds_bad); end
            total++;
            if (done_cnt != 1 || done_cyc != last_x + 1 || busy_after !== 1'b0) begin
                bad++;
                $display("FAIL rand_done[%0d]: got count=%0d cyc=%0d busy_after=%b expected 1 %0d 0",
                         it, done_cnt, done_cyc, busy_after, last_x + 1);
            end
        end
    endtask

`ifdef DEBUG_READER_CKSUM_EN
    task automatic test_cksum_single();
        logic [BUS_W-1:0] snap;
        snap = '0;
        snap[63:0] = 64'h01;
        collect(snap, 2, -1, 1'b0, -1);
        total++;
        if (timed_out || got_q.size() != BYTES + 1 || got_q[BYTES] !== 8'h01) begin
            bad++;
            $display("FAIL cksum_single: got %0d bytes last=%h expected %0d bytes last=01",
                     got_q.size(), got_q.size() ? got_q[got_q.size() - 1] : 8'hxx, BYTES + 1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_speed();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_dump();
        test_random();
`ifdef DEBUG_READER_CKSUM_EN
        test_cksum_single();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
